// File: rtl/mark_clock_div.sv
// mark_clock_div: multi-channel divided-clock and tick generator with glitch-free start/stop and global cycle budget
module mark_clock_div #(
  parameter int          NUM_CH      = 4,
  parameter int          DIV_W       = 16,
  parameter int          DEFAULT_DIV = 2,
  parameter int unsigned END_CYCLES  = 0,
  parameter int          CNT_W       = 32,
  localparam int         CH_W        = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] run,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running,
  output logic              done,
  output logic [CNT_W-1:0]  cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  logic [CNT_W-1:0] cyc_nx;
  logic             done_nx;
  assign cyc_nx  = &cycles ? cycles : cycles + CNT_W'(1);
  assign done_nx = done | (END_CYCLES != 0 && cyc_nx == CNT_W'(END_CYCLES));
  // Saturating cycle counter and sticky budget flag.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycles <= '0;
      done   <= 1'b0;
    end else begin
      cycles <= cyc_nx;
      done   <= done_nx;
    end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           st, st_nx;
    logic [DIV_W-1:0] ph, ph_nx, adiv, adiv_nx, sdiv, hi;
    logic             stay, last, act, cd, tk, rn;
    assign stay = run[g] && !done_nx;
    assign last = ph == adiv - DIV_W'(1);
    assign act  = st_nx != IDLE;
    assign hi   = (adiv_nx >> 1) + DIV_W'(adiv_nx[0]);
    // Next state: starts and stops only ever happen on a period boundary, so no runt pulses.
    always_comb begin
      st_nx   = st;
      ph_nx   = ph;
      adiv_nx = adiv;
      if (st == IDLE) begin
        st_nx   = stay && sdiv != '0 ? RUN : IDLE;
        adiv_nx = stay && sdiv != '0 ? sdiv : adiv;
      end else if (last) begin
        ph_nx   = '0;
        adiv_nx = sdiv;
        st_nx   = stay && sdiv != '0 ? RUN : IDLE;
      end else begin
        ph_nx = ph + DIV_W'(1);
        st_nx = stay ? RUN : DRAIN;
      end
    end
    // Channel state plus outputs registered from the post-edge state.
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        st   <= IDLE;
        ph   <= '0;
        adiv <= '0;
        sdiv <= DIV_W'(DEFAULT_DIV);
        cd   <= 1'b0;
        tk   <= 1'b0;
        rn   <= 1'b0;
      end else begin
        if (cfg_we && cfg_ch == CH_W'(g)) sdiv <= cfg_div;
        st   <= st_nx;
        ph   <= ph_nx;
        adiv <= adiv_nx;
        cd   <= act && ph_nx < hi;
        tk   <= act && ph_nx == adiv_nx - DIV_W'(1);
        rn   <= act;
      end
    assign clk_div[g] = cd;
    assign tick[g]    = tk;
    assign running[g] = rn;
  end
endmodule

// File: doc/mark_clock_div.md
# mark_clock_div

Synthesizable multi-channel clock-enable and divided-clock generator, the successor of the simulation clock model for the Golomb ruler search engines. From the single system clock it derives NUM_CH independently programmable divided clocks and one-cycle tick strobes, with glitch-free start and stop. A global cycle budget replaces the old end-of-simulation timeout: reaching it asserts a sticky done flag and drains every channel cleanly.

## Interface
- NUM_CH, 4: number of output channels (1..16)
- DIV_W, 16: divisor width
- DEFAULT_DIV, 2: reset value of every channel's shadow divisor (0 = disabled)
- END_CYCLES, 0: global cycle budget; 0 disables the budget
- CNT_W, 32: width of the global cycle counter
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- cfg_we  in  1  write strobe for the shadow divisor
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel written by cfg_we
- cfg_div  in  DIV_W  divisor value written
- run  in  NUM_CH  per-channel run request, level sensitive
- clk_div  out  NUM_CH  divided clock per channel, registered
- tick  out  NUM_CH  one-cycle strobe on the last cycle of each period, registered
- running  out  NUM_CH  channel in RUN or DRAIN
- done  out  1  sticky budget-reached flag
- cycles  out  CNT_W  clock edges since reset release, saturating

## Operation
- Per channel: shadow divisor sdiv, active divisor adiv, phase counter ph (DIV_W bits), state IDLE/RUN/DRAIN.
- cfg_we with cfg_ch < NUM_CH writes cfg_div to sdiv at the clock edge; cfg_ch >= NUM_CH is ignored. sdiv is never used directly by a running period.
- High phase H = ceil(adiv/2). In RUN/DRAIN: clk_div = (ph < H), tick = (ph == adiv-1). adiv=1: clk_div constant 1, tick every cycle. adiv=2: 50% duty. adiv=3: 2 high, 1 low.
- IDLE: ph=0, clk_div=0, tick=0. Leave for RUN when run[i]=1, sdiv != 0 and done=0; adiv <= sdiv on that edge.
- RUN: ph increments each cycle, wraps to 0 after adiv-1. On the edge ending a period (ph == adiv-1): adiv <= sdiv; if sdiv == 0, go to IDLE. run[i]=0 or done=1 sampled -> DRAIN.
- DRAIN: keeps counting; edge ending the period -> IDLE. run[i]=1 with done=0 sampled before that edge -> back to RUN, no gap in the waveform.
- Stop therefore always lands after a complete period; clk_div never produces a runt pulse.
- cycles increments every edge with reset high, saturating at all-ones. With END_CYCLES != 0, done sets on the edge where cycles becomes END_CYCLES, and stays set until reset.

## Timing
- Reset (async, reset=0): clk_div=0, tick=0, running=0, done=0, cycles=0, all states IDLE, ph=0, adiv=0, sdiv=DEFAULT_DIV. Outputs go low immediately on assertion, no clock required.
- Start latency: run sampled high at edge E -> running, clk_div reflect ph=0 from edge E (same registered update), i.e. visible one cycle after run is presented.
- All outputs registered; no combinational path from inputs to outputs.
- Config written at edge E while running takes effect at the first period boundary after E; while IDLE it is used by the next start.
- Simultaneous cfg_we and period boundary on same channel: boundary loads the old sdiv; new value applies at the following boundary.
- Simultaneous done set and run rising in IDLE: channel stays IDLE.
- Reset mid-period: outputs drop at once; no drain.

## Test plan
- Reset release, run[0]=1, DEFAULT_DIV=2 -> clk_div[0] toggles 1,0,1,0 from the cycle after run; tick[0] high every 2nd cycle coinciding with clk_div=0.
- cfg ch1 div=3, run[1]=1 for 10 cycles then 0 mid-period -> pattern 1,1,0 repeating, stop only after a full period ends; running[1] falls with clk_div[1]=0, no runt.
- Write div=5 to ch0 while running at div=2 -> current period completes at 2, next periods are 3 high/2 low; write coincident with boundary delays change by one period.
- Write div=0 while running -> channel stops at next boundary, running=0; later write div=4, run high -> restarts.
- END_CYCLES=100, all channels running -> done rises on cycle 100, every channel drains to IDLE, run high no longer restarts; cycles keeps counting.
- Assert reset mid-period with div=7 -> all outputs 0 asynchronously, sdiv back to DEFAULT_DIV after release.
